// File: rtl/cpu_mem_if.sv
// cpu_mem_if -- CPU <-> memory bus bundle.
//   master : CPU side (drives fetch address, data requests and IMEM preload)
//   slave  : memory side (returns instruction, load data, completion and status)
// Signals:
//   inst_addr/instr                      instruction fetch (combinational)
//   data_addr/data_in/mem_read/mem_write data request
//   data_out/mem_ready                   load result, one-cycle completion pulse
//   halted/addr_err                      sticky status flags
//   load_en/load_addr/load_data          program preload into IMEM
interface cpu_mem_if;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        halted;
    logic        addr_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output inst_addr, data_addr, data_in, mem_read, mem_write,
               load_en, load_addr, load_data,
        input  instr, data_out, mem_ready, halted, addr_err
    );

    modport slave (
        input  inst_addr, data_addr, data_in, mem_read, mem_write,
               load_en, load_addr, load_data,
        output instr, data_out, mem_ready, halted, addr_err
    );
endinterface

// File: rtl/cpu_mem.sv
// cpu_mem -- instruction memory with combinational fetch plus data memory
// behind a fixed-latency request FSM (IDLE -> WAIT -> RESP).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (memories are not cleared)
//   bus  : cpu_mem_if.slave (fetch, data request/response, preload, status)
module cpu_mem #(
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned DATA_LAT   = 2
) (
    input  logic      clk,
    input  logic      rst,
    cpu_mem_if.slave  bus
);
    localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0]    r_imem [IMEM_WORDS];
    logic [31:0]    r_dmem [DMEM_WORDS];

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [31:0]    r_data_out;
    logic           r_halted;
    logic           r_addr_err;
    logic           r_ld;
    logic           r_err;
    logic [DAW-1:0] r_idx;

    logic [29:0]    w_i_word, w_l_word, w_d_word;
    logic           w_i_eof, w_i_ok, w_l_ok, w_d_ok;
    logic           w_d_ld, w_d_st, w_d_err;
    logic           w_accept;
    logic [31:0]    w_instr;

    // Word index from unsigned offset; an address below BASE wraps to a huge
    // offset and therefore fails the range test instead of aliasing.
    always_comb begin
        w_i_word = 30'((bus.inst_addr - IMEM_BASE) >> 2);
        w_l_word = 30'((bus.load_addr - IMEM_BASE) >> 2);
        w_d_word = 30'((bus.data_addr - DMEM_BASE) >> 2);
        w_i_eof  = (bus.inst_addr == 32'hFFFF_FFFF);
        w_i_ok   = (bus.inst_addr[1:0] == 2'b00) && ({2'b00, w_i_word} < IMEM_WORDS);
        w_l_ok   = (bus.load_addr[1:0] == 2'b00) && ({2'b00, w_l_word} < IMEM_WORDS);
        w_d_ok   = (bus.data_addr[1:0] == 2'b00) && ({2'b00, w_d_word} < DMEM_WORDS);
        w_d_ld   = bus.mem_read & ~bus.mem_write;
        w_d_st   = bus.mem_write & ~bus.mem_read;
        // Simultaneous read+write is treated as an error with no access.
        w_d_err  = ~w_d_ok | (bus.mem_read & bus.mem_write);
        w_instr  = '0;
        if (w_i_eof)
            w_instr = '1;
        else if (w_i_ok)
            w_instr = r_imem[w_i_word[IAW-1:0]];
    end

    // Preload has priority over a CPU request in IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        unique case (r_state)
            IDLE: if ((bus.mem_read || bus.mem_write) && !bus.load_en) begin
                w_accept = 1'b1;
                w_next   = (DATA_LAT == 1) ? RESP : WAIT;
            end
            WAIT: if (r_cnt <= 4'd1) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_data_out <= '0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
            r_ld       <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
        end else begin
            if (w_i_eof)
                r_halted <= 1'b1;
            else if (!w_i_ok)
                r_addr_err <= 1'b1;
            if (bus.load_en && !w_l_ok)
                r_addr_err <= 1'b1;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_cnt <= 4'(DATA_LAT - 1);
                    r_ld  <= w_d_ld;
                    r_err <= w_d_err;
                    r_idx <= w_d_word[DAW-1:0];
                    if (w_d_err)
                        r_addr_err <= 1'b1;
                    // Single-cycle latency enters RESP at the accept edge.
                    if (DATA_LAT == 1 && w_d_ld)
                        r_data_out <= w_d_err ? '0 : r_dmem[w_d_word[DAW-1:0]];
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_next == RESP && r_ld)
                        r_data_out <= r_err ? '0 : r_dmem[r_idx];
                end
                default: ;
            endcase
        end
    end

    // Preload is honoured regardless of reset.
    always_ff @(posedge clk) begin
        if (bus.load_en && w_l_ok)
            r_imem[w_l_word[IAW-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_d_st && w_d_ok && !r_halted)
            r_dmem[w_d_word[DAW-1:0]] <= bus.data_in;
    end

    assign bus.instr     = w_instr;
    assign bus.data_out  = r_data_out;
    assign bus.mem_ready = (r_state == RESP);
    assign bus.halted    = r_halted;
    assign bus.addr_err  = r_addr_err;
endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem -- directed self-checking bench for cpu_mem (default parameters,
// DATA_LAT = 2).
module tb_cpu_mem;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_mem_if bus ();

    cpu_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise a request, hold it until mem_ready is seen, then drop it.
    // lat counts sampling cycles until mem_ready; 99 means it never came.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int lat,
                             output logic [31:0] rdata);
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.data_addr = addr;
        bus.data_in   = data;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdata = bus.data_out;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h0000_3000;
        bus.load_data = 32'h8C01_0004;
        @(negedge clk);
        bus.load_addr = 32'h0000_33FC;
        bus.load_data = 32'h0123_4567;
        @(negedge clk);
        bus.load_en = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.instr !== 32'h8C01_0004) begin
            n_errors++; $display("FAIL reset_instr: got %h expected %h", bus.instr, 32'h8C01_0004);
        end
        n_checks++;
        if ({bus.mem_ready, bus.halted, bus.addr_err} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 000", {bus.mem_ready, bus.halted, bus.addr_err});
        end
        n_checks++;
        if (bus.data_out !== 32'h0) begin
            n_errors++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.inst_addr = 32'h0000_33FC;
        #1;
        n_checks++;
        if (bus.instr !== 32'h0123_4567) begin
            n_errors++; $display("FAIL fetch_last: got %h expected %h", bus.instr, 32'h0123_4567);
        end
        @(negedge clk);
        n_checks++;
        if (bus.addr_err !== 1'b0) begin
            n_errors++; $display("FAIL fetch_last_err: got %b expected 0", bus.addr_err);
        end
        bus.inst_addr = 32'h0000_2FFC;
        #1;
        n_checks++;
        if (bus.instr !== 32'h0) begin
            n_errors++; $display("FAIL fetch_below_base: got %h expected 0", bus.instr);
        end
        bus.inst_addr = 32'h0000_3002;
        #1;
        n_checks++;
        if (bus.instr !== 32'h0) begin
            n_errors++; $display("FAIL fetch_misaligned: got %h expected 0", bus.instr);
        end
        @(negedge clk);
        bus.inst_addr = 32'h0000_3000;
        n_checks++;
        if (bus.addr_err !== 1'b1) begin
            n_errors++; $display("FAIL fetch_err_flag: got %b expected 1", bus.addr_err);
        end
        do_reset();
        n_checks++;
        if (bus.addr_err !== 1'b0) begin
            n_errors++; $display("FAIL fetch_err_clear: got %b expected 0", bus.addr_err);
        end
    endtask

    task automatic test_store_load();
        int          lat;
        logic [31:0] rd;
        do_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd);
        n_checks++;
        if (lat !== 2) begin
            n_errors++; $display("FAIL store_lat: got %0d expected 2", lat);
        end
        n_checks++;
        if (rd !== 32'h0) begin
            n_errors++; $display("FAIL store_data_out: got %h expected 0", rd);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_ready !== 1'b0) begin
            n_errors++; $display("FAIL ready_pulse_width: got %b expected 0", bus.mem_ready);
        end
        do_access(1'b0, 1'b1, 32'h0, 32'h1111_2222, lat, rd);
        do_access(1'b0, 1'b1, 32'h3FC, 32'h1234_5678, lat, rd);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL load_10: got lat=%0d data=%h expected lat=2 data=%h", lat, rd, 32'hDEAD_BEEF);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.data_out !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL load_hold: got %h expected %h", bus.data_out, 32'hDEAD_BEEF);
        end
        do_access(1'b1, 1'b0, 32'h3FC, 32'h0, lat, rd);
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_errors++; $display("FAIL load_last_word: got %h expected %h", rd, 32'h1234_5678);
        end
        n_checks++;
        if (bus.addr_err !== 1'b0) begin
            n_errors++; $display("FAIL store_load_err: got %b expected 0", bus.addr_err);
        end
    endtask

    task automatic test_addr_err();
        int          lat;
        logic [31:0] rd;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
        do_access(1'b1, 1'b0, 32'h11, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'h0) begin
            n_errors++; $display("FAIL misaligned_load: got lat=%0d data=%h expected lat=2 data=0", lat, rd);
        end
        n_checks++;
        if (bus.addr_err !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_err: got %b expected 1", bus.addr_err);
        end
        do_reset();
        do_access(1'b0, 1'b1, 32'h400, 32'hAAAA_5555, lat, rd);
        n_checks++;
        if (lat !== 2 || bus.addr_err !== 1'b1) begin
            n_errors++; $display("FAIL oor_store: got lat=%0d err=%b expected lat=2 err=1", lat, bus.addr_err);
        end
        do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, rd);
        n_checks++;
        if (rd !== 32'h1111_2222) begin
            n_errors++; $display("FAIL oor_no_write: got %h expected %h", rd, 32'h1111_2222);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] rd;
        do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, rd);
        @(negedge clk);
        bus.mem_read  = 1'b1;
        bus.data_addr = 32'h10;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.mem_ready !== 1'b0 || bus.data_out !== 32'h0) begin
            n_errors++; $display("FAIL reset_abort: got ready=%b data=%h expected ready=0 data=0", bus.mem_ready, bus.data_out);
        end
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.mem_read = 1'b0;
        n_checks++;
        if (lat !== 2 || bus.data_out !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL load_after_reset: got lat=%0d data=%h expected lat=2 data=%h", lat, bus.data_out, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_both_and_load_en();
        int          lat;
        int          seen;
        logic [31:0] rd;
        do_reset();
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
        do_access(1'b1, 1'b1, 32'h10, 32'h5555_5555, lat, rd);
        n_checks++;
        if (lat !== 2 || bus.addr_err !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL both_req: got lat=%0d err=%b data=%h expected lat=2 err=1 data=%h", lat, bus.addr_err, rd, 32'hDEAD_BEEF);
        end
        do_reset();
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL both_no_write: got %h expected %h", rd, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h0000_3004;
        bus.load_data = 32'hCAFE_F00D;
        bus.mem_read  = 1'b1;
        bus.data_addr = 32'h0;
        @(negedge clk);
        bus.load_en  = 1'b0;
        bus.mem_read = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL load_en_blocks_req: got %0d ready pulses expected 0", seen);
        end
        bus.inst_addr = 32'h0000_3004;
        #1;
        n_checks++;
        if (bus.instr !== 32'hCAFE_F00D) begin
            n_errors++; $display("FAIL load_en_write: got %h expected %h", bus.instr, 32'hCAFE_F00D);
        end
        @(negedge clk);
        bus.inst_addr = 32'h0000_3000;
    endtask

    task automatic test_halt();
        int          lat;
        logic [31:0] rd;
        @(negedge clk);
        bus.inst_addr = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (bus.instr !== 32'hFFFF_FFFF || bus.halted !== 1'b0) begin
            n_errors++; $display("FAIL eof_fetch: got instr=%h halted=%b expected instr=ffffffff halted=0", bus.instr, bus.halted);
        end
        @(negedge clk);
        bus.inst_addr = 32'h0000_3000;
        n_checks++;
        if (bus.halted !== 1'b1 || bus.addr_err !== 1'b0) begin
            n_errors++; $display("FAIL halted_set: got halted=%b err=%b expected halted=1 err=0", bus.halted, bus.addr_err);
        end
        do_access(1'b0, 1'b1, 32'h0, 32'h9999_9999, lat, rd);
        n_checks++;
        if (lat !== 2) begin
            n_errors++; $display("FAIL halted_store_ready: got %0d expected 2", lat);
        end
        do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, rd);
        n_checks++;
        if (rd !== 32'h1111_2222) begin
            n_errors++; $display("FAIL halted_store_suppressed: got %h expected %h", rd, 32'h1111_2222);
        end
        #1;
        n_checks++;
        if (bus.instr !== 32'h8C01_0004 || bus.halted !== 1'b1) begin
            n_errors++; $display("FAIL halted_fetch: got instr=%h halted=%b expected instr=8c010004 halted=1", bus.instr, bus.halted);
        end
        do_reset();
        n_checks++;
        if (bus.halted !== 1'b0) begin
            n_errors++; $display("FAIL halted_clear: got %b expected 0", bus.halted);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.inst_addr = 32'h0000_3000;
        bus.data_addr = '0;
        bus.data_in   = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_addr_err();
        test_reset_mid();
        test_both_and_load_en();
        test_halt();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
